// File: rtl/control_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | control_unit: multi-cycle FSM sequencer and ALU op decoder, 16-bit CPU  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module control_unit #(
  parameter logic [4:0] NOP_OP = 5'd10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] ir_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic [4:0]  alu_op_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic [1:0]  pc_src_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        reg_src_o,
  output logic [1:0]  cwp_o,
  output logic        instr_done_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_BR     = 3'd4,
    S_MEM_LD = 3'd5,
    S_MEM_ST = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    K_NOP   = 3'd0,
    K_LOAD  = 3'd1,
    K_STORE = 3'd2,
    K_JUMP  = 3'd3,
    K_BRZ   = 3'd4,
    K_ALU   = 3'd5,
    K_WND   = 3'd6
  } kind_e;

  state_e      state_q;
  logic [1:0]  cwp_q;

  kind_e       dec_kind;
  logic [4:0]  dec_alu_op;
  logic [1:0]  dec_wnd;
  logic [3:0]  func;
  logic        unused_ir_bits;

  assign func           = ir_i[3:0];
  assign unused_ir_bits = ^ir_i[11:4];

  always_comb begin
    dec_kind   = K_NOP;
    dec_alu_op = NOP_OP;
    // func 7..10 maps to window 0..3: low two bits plus one, modulo 4
    dec_wnd    = ir_i[1:0] + 2'd1;
    case (ir_i[15:12])
      4'b0000: dec_kind = K_LOAD;
      4'b0001: dec_kind = K_STORE;
      4'b0010: dec_kind = K_JUMP;
      4'b0100: begin
        dec_kind   = K_BRZ;
        dec_alu_op = 5'd3;
      end
      4'b1000: begin
        if (func <= 4'd5) begin
          dec_kind   = K_ALU;
          dec_alu_op = {1'b0, func} + 5'd4;
        end else if (func >= 4'd7 && func <= 4'd10) begin
          dec_kind = K_WND;
        end
      end
      4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
        dec_kind   = K_ALU;
        dec_alu_op = {1'b0, ir_i[15:12]} + 5'd3;
      end
      default: dec_kind = K_NOP;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cwp_q   <= 2'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready_i) state_q <= S_DECODE;
        end
        S_DECODE: begin
          case (dec_kind)
            K_LOAD:  state_q <= S_MEM_LD;
            K_STORE: state_q <= S_MEM_ST;
            K_ALU,
            K_BRZ:   state_q <= S_EXEC;
            K_WND: begin
              cwp_q   <= dec_wnd;
              state_q <= S_FETCH;
            end
            default: state_q <= S_FETCH;
          endcase
        end
        S_EXEC:   state_q <= (dec_kind == K_BRZ) ? S_BR : S_WB;
        S_WB:     state_q <= S_FETCH;
        S_BR:     state_q <= S_FETCH;
        S_MEM_LD: begin
          if (mem_ready_i) state_q <= S_FETCH;
        end
        S_MEM_ST: begin
          if (mem_ready_i) state_q <= S_FETCH;
        end
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Reset gates every strobe combinationally so an aborted write dies immediately
  always_comb begin
    alu_op_o     = NOP_OP;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'd0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_src_o    = 1'b0;
    instr_done_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          mem_read_o = 1'b1;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
          end
        end
        S_DECODE: begin
          case (dec_kind)
            K_JUMP: begin
              pc_write_o   = 1'b1;
              pc_src_o     = 2'd1;
              instr_done_o = 1'b1;
            end
            K_NOP, K_WND: instr_done_o = 1'b1;
            default: instr_done_o = 1'b0;
          endcase
        end
        S_EXEC: alu_op_o = dec_alu_op;
        S_WB: begin
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_BR: begin
          if (zero_i) begin
            pc_write_o = 1'b1;
            pc_src_o   = 2'd2;
          end
          instr_done_o = 1'b1;
        end
        S_MEM_LD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
          if (mem_ready_i) begin
            reg_write_o  = 1'b1;
            reg_src_o    = 1'b1;
            instr_done_o = 1'b1;
          end
        end
        S_MEM_ST: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
          if (mem_ready_i) instr_done_o = 1'b1;
        end
        default: alu_op_o = NOP_OP;
      endcase
    end
  end

  assign cwp_o = cwp_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// tb_control_unit: directed per-cycle vectors checked through an expected-result queue.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        zero;
  logic        mem_ready;
  logic [4:0]  alu_op;
  logic        ir_write, pc_write, iord, mem_read, mem_write;
  logic        reg_write, reg_src, instr_done;
  logic [1:0]  pc_src, cwp;
  logic [16:0] obs;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [16:0] vec;
  } sb_t;
  sb_t sb[$];

  control_unit #(.NOP_OP(5'd10)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ir_i         (ir),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .alu_op_o     (alu_op),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .pc_src_o     (pc_src),
    .iord_o       (iord),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .reg_write_o  (reg_write),
    .reg_src_o    (reg_src),
    .cwp_o        (cwp),
    .instr_done_o (instr_done)
  );

  always #5 clk = ~clk;

  assign obs = {alu_op, ir_write, pc_write, pc_src, iord, mem_read, mem_write,
                reg_write, reg_src, cwp, instr_done};

  function automatic logic [16:0] ex(input logic [4:0] a, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic io, input logic mr,
                                     input logic mw, input logic rw, input logic rs,
                                     input logic [1:0] c, input logic d);
    return {a, irw, pcw, pcs, io, mr, mw, rw, rs, c, d};
  endfunction

  // Apply one cycle of inputs after the falling edge, then check settled outputs.
  task automatic cyc(input logic r, input logic [15:0] i, input logic z, input logic rdy,
                     input logic [16:0] e, input string tag);
    sb_t item;
    @(negedge clk);
    rst       = r;
    ir        = i;
    zero      = z;
    mem_ready = rdy;
    sb.push_back('{tag, e});
    #2;
    item = sb.pop_front();
    vectors++;
    assert (obs === item.vec) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", item.tag, obs, item.vec);
    end
  endtask

  initial begin
    rst = 1'b1; ir = 16'h8006; zero = 1'b0; mem_ready = 1'b1;

    cyc(1, 16'h8006, 0, 1, ex(10,0,0,0,0,0,0,0,0,0,0), "reset_idle");
    cyc(1, 16'h8006, 0, 1, ex(10,0,0,0,0,0,0,0,0,0,0), "reset_hold");

    // NOP: 2 cycles
    cyc(0, 16'h8006, 0, 1, ex(10,1,1,0,0,1,0,0,0,0,0), "nop_fetch");
    cyc(0, 16'h8006, 0, 1, ex(10,0,0,0,0,0,0,0,0,0,1), "nop_decode");

    // SUB with one fetch wait cycle
    cyc(0, 16'h8002, 0, 0, ex(10,0,0,0,0,1,0,0,0,0,0), "sub_fetch_wait");
    cyc(0, 16'h8002, 0, 1, ex(10,1,1,0,0,1,0,0,0,0,0), "sub_fetch");
    cyc(0, 16'h8002, 0, 1, ex(10,0,0,0,0,0,0,0,0,0,0), "sub_decode");
    cyc(0, 16'h8002, 0, 1, ex( 6,0,0,0,0,0,0,0,0,0,0), "sub_exec");
    cyc(0, 16'h8002, 0, 1, ex(10,0,0,0,0,0,0,1,0,0,1), "sub_wb");

    // LOAD with three wait cycles in MEM_LD
    cyc(0, 16'h0123, 0, 1, ex(10,1,1,0,0,1,0,0,0,0,0), "ld_fetch");
    cyc(0, 16'h0123, 0, 1, ex(10,0,0,0,0,0,0,0,0,0,0), "ld_decode");
    cyc(0, 16'h0123, 0, 0, ex(10,0,0,0,1,1,0,0,0,0,0), "ld_wait1");
    cyc(0, 16'h0123, 0, 0, ex(10,0,0,0,1,1,0,0,0,0,0), "ld_wait2");
    cyc(0, 16'h0123, 0, 0, ex(10,0,0,0,1,1,0,0,0,0,0), "ld_wait3");
    cyc(0, 16'h0123, 0, 1, ex(10,0,0,0,1,1,0,1,1,0,1), "ld_ready");

    // BRANCH_Z taken
    cyc(0, 16'h4005, 0, 1, ex(10,1,1,0,0,1,0,0,0,0,0), "brt_fetch");
    cyc(0, 16'h4005, 0, 1, ex(10,0,0,0,0,0,0,0,0,0,0), "brt_decode");
    cyc(0, 16'h4005, 0, 1, ex( 3,0,0,0,0,0,0,0,0,0,0), "brt_exec");
    cyc(0, 16'h4005, 1, 1, ex(10,0,1,2,0,0,0,0,0,0,1), "brt_br");

    // BRANCH_Z with zero high only before BR: not taken
    cyc(0, 16'h4005, 1, 1, ex(10,1,1,0,0,1,0,0,0,0,0), "brn_fetch");
    cyc(0, 16'h4005, 1, 1, ex(10,0,0,0,0,0,0,0,0,0,0), "brn_decode");
    cyc(0, 16'h4005, 1, 1, ex( 3,0,0,0,0,0,0,0,0,0,0), "brn_exec");
    cyc(0, 16'h4005, 0, 1, ex(10,0,0,0,0,0,0,0,0,0,1), "brn_br");

    // JUMP
    cyc(0, 16'h2ABC, 0, 1, ex(10,1,1,0,0,1,0,0,0,0,0), "jmp_fetch");
    cyc(0, 16'h2ABC, 0, 1, ex(10,0,1,1,0,0,0,0,0,0,1), "jmp_decode");

    // WND2 then ADDI keeps cwp=2
    cyc(0, 16'h8009, 0, 1, ex(10,1,1,0,0,1,0,0,0,0,0), "wnd2_fetch");
    cyc(0, 16'h8009, 0, 1, ex(10,0,0,0,0,0,0,0,0,0,1), "wnd2_decode");
    cyc(0, 16'hC012, 0, 1, ex(10,1,1,0,0,1,0,0,0,2,0), "addi_fetch");
    cyc(0, 16'hC012, 0, 1, ex(10,0,0,0,0,0,0,0,0,2,0), "addi_decode");
    cyc(0, 16'hC012, 0, 1, ex(15,0,0,0,0,0,0,0,0,2,0), "addi_exec");
    cyc(0, 16'hC012, 0, 1, ex(10,0,0,0,0,0,0,1,0,2,1), "addi_wb");

    // WND3 then ORI with undefined func word in between
    cyc(0, 16'h800A, 0, 1, ex(10,1,1,0,0,1,0,0,0,2,0), "wnd3_fetch");
    cyc(0, 16'h800A, 0, 1, ex(10,0,0,0,0,0,0,0,0,2,1), "wnd3_decode");
    cyc(0, 16'h800F, 0, 1, ex(10,1,1,0,0,1,0,0,0,3,0), "badfn_fetch");
    cyc(0, 16'h800F, 0, 1, ex(10,0,0,0,0,0,0,0,0,3,1), "badfn_decode");
    cyc(0, 16'hF0F0, 0, 1, ex(10,1,1,0,0,1,0,0,0,3,0), "ori_fetch");
    cyc(0, 16'hF0F0, 0, 1, ex(10,0,0,0,0,0,0,0,0,3,0), "ori_decode");
    cyc(0, 16'hF0F0, 0, 1, ex(18,0,0,0,0,0,0,0,0,3,0), "ori_exec");
    cyc(0, 16'hF0F0, 0, 1, ex(10,0,0,0,0,0,0,1,0,3,1), "ori_wb");

    // MOVE decode
    cyc(0, 16'h8000, 0, 1, ex(10,1,1,0,0,1,0,0,0,3,0), "mov_fetch");
    cyc(0, 16'h8000, 0, 1, ex(10,0,0,0,0,0,0,0,0,3,0), "mov_decode");
    cyc(0, 16'h8000, 0, 1, ex( 4,0,0,0,0,0,0,0,0,3,0), "mov_exec");
    cyc(0, 16'h8000, 0, 1, ex(10,0,0,0,0,0,0,1,0,3,1), "mov_wb");

    // STORE aborted by reset during the wait
    cyc(0, 16'h1FFF, 0, 1, ex(10,1,1,0,0,1,0,0,0,3,0), "st_fetch");
    cyc(0, 16'h1FFF, 0, 1, ex(10,0,0,0,0,0,0,0,0,3,0), "st_decode");
    cyc(0, 16'h1FFF, 0, 0, ex(10,0,0,0,1,0,1,0,0,3,0), "st_wait1");
    cyc(0, 16'h1FFF, 0, 0, ex(10,0,0,0,1,0,1,0,0,3,0), "st_wait2");
    cyc(1, 16'h1FFF, 0, 0, ex(10,0,0,0,0,0,0,0,0,0,0), "st_abort");

    // Undefined opcode after reset release behaves as NOP
    cyc(0, 16'h3FFF, 0, 1, ex(10,1,1,0,0,1,0,0,0,0,0), "undef_fetch");
    cyc(0, 16'h3FFF, 0, 1, ex(10,0,0,0,0,0,0,0,0,0,1), "undef_decode");
    cyc(0, 16'h3FFF, 0, 0, ex(10,0,0,0,0,1,0,0,0,0,0), "undef_next_fetch");

    // Completed STORE with zero wait
    cyc(0, 16'h1234, 0, 1, ex(10,1,1,0,0,1,0,0,0,0,0), "st2_fetch");
    cyc(0, 16'h1234, 0, 1, ex(10,0,0,0,0,0,0,0,0,0,0), "st2_decode");
    cyc(0, 16'h1234, 0, 1, ex(10,0,0,0,1,0,1,0,0,0,1), "st2_ready");
    cyc(0, 16'h8006, 0, 0, ex(10,0,0,0,0,1,0,0,0,0,0), "st2_back_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
